// File: rtl/md_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: md opcode encodings,
// default busy-cycle counts and the opcode-class helper.
package md_sched_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  function automatic logic md_is_arith(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic md_is_mult(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_sched_calc.sv
// Combinational mult/div datapath: (op, a, b) -> {res_hi, res_lo, div0}.
// Division result is LO = quotient, HI = remainder.
module md_calc
  import md_sched_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic [63:0] res;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        sgn;

  always_comb begin
    res   = '0;
    mag_a = a;
    mag_b = b;
    quo   = '0;
    rem   = '0;
    div0  = 1'b0;
    sgn   = (op == MD_DIV);
    case (op)
      MD_MULT:  res = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MD_MULTU: res = {32'b0, a} * {32'b0, b};
      MD_DIV, MD_DIVU: begin
        // Signed divide on magnitudes keeps 0x80000000 / -1 well defined
        // and gives truncation toward zero with remainder sign of dividend.
        if (sgn && a[31]) mag_a = -a;
        if (sgn && b[31]) mag_b = -b;
        div0 = (b == '0);
        if (!div0) begin
          quo = mag_a / mag_b;
          rem = mag_a % mag_b;
        end
        if (sgn && (a[31] ^ b[31])) quo = -quo;
        if (sgn && a[31]) rem = -rem;
        res = {rem, quo};
      end
      default: ;
    endcase
    res_hi = res[63:32];
    res_lo = res[31:0];
  end

endmodule

// File: rtl/md_sched.sv
// E-stage multiply/divide scheduler: owns HI/LO, models mult/div latency with
// a down-counter and raises the D-stage stall while an operation is in flight.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_md_use,
  output logic        start,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] E_md_rd,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [3:0]  counter;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_ok;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        calc_div0;

  md_calc u_calc (
    .op     (E_md_op),
    .a      (E_A),
    .b      (E_B),
    .res_hi (calc_hi),
    .res_lo (calc_lo),
    .div0   (calc_div0)
  );

  assign busy     = (counter != '0);
  assign start    = md_is_arith(E_md_op) && !busy;
  assign md_stall = D_md_use && (start || busy);

  always_comb begin
    E_md_rd = '0;
    if (E_md_op == MD_MFHI) E_md_rd = hi;
    else if (E_md_op == MD_MFLO) E_md_rd = lo;
  end

  // Priority start > countdown > mthi/mtlo makes writes while busy a no-op.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_ok <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (start) begin
      pend_hi <= calc_hi;
      pend_lo <= calc_lo;
      pend_ok <= !calc_div0;
      counter <= md_is_mult(E_md_op) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
    end else if (busy) begin
      counter <= counter - 4'd1;
      if (counter == 4'd1 && pend_ok) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (E_md_op == MD_MTHI) begin
      hi <= E_A;
    end else if (E_md_op == MD_MTLO) begin
      lo <= E_A;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed test-plan sequences with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_md_op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_md_use;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] E_md_rd;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Reference state: architectural HI/LO, remaining busy cycles, queued result.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          m_left = 0;
  logic [31:0] m_p_hi = '0;
  logic [31:0] m_p_lo = '0;
  bit          m_p_ok = 1'b0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .E_md_op  (E_md_op),
    .E_A      (E_A),
    .E_B      (E_B),
    .D_md_use (D_md_use),
    .start    (start),
    .busy     (busy),
    .md_stall (md_stall),
    .E_md_rd  (E_md_rd),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Full-width arithmetic reference: {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r, p;
    longint unsigned up;
    logic [31:0] uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ref_result = '0;
    case (op)
      4'd1: begin p = sa * sb; ref_result = p; end
      4'd2: begin up = longint'(a) * longint'(b); ref_result = up; end
      4'd3: begin q = sa / sb; r = sa % sb; ref_result = {r[31:0], q[31:0]}; end
      4'd4: begin uq = a / b; ur = a % b; ref_result = {ur, uq}; end
      default: ;
    endcase
  endfunction

  // Compare process plus model step; inputs are stable from posedge+1 to next posedge.
  always @(negedge clk) begin
    bit          e_busy, e_start, arith;
    logic [31:0] e_rd;
    logic [63:0] r;
    arith   = (E_md_op >= 4'd1) && (E_md_op <= 4'd4);
    e_busy  = (m_left > 0);
    e_start = arith && !e_busy;
    e_rd    = (E_md_op == 4'd5) ? m_hi : (E_md_op == 4'd6) ? m_lo : 32'h0;
    if (cmp_en) begin
      check("busy", 32'(busy), 32'(e_busy));
      check("start", 32'(start), 32'(e_start));
      check("md_stall", 32'(md_stall), 32'(D_md_use && (e_start || e_busy)));
      check("E_md_rd", E_md_rd, e_rd);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_p_ok = 1'b0;
    end else if (e_start) begin
      r      = ref_result(E_md_op, E_A, E_B);
      m_p_hi = r[63:32];
      m_p_lo = r[31:0];
      m_p_ok = !((E_md_op >= 4'd3) && (E_B == 32'h0));
      m_left = (E_md_op <= 4'd2) ? 5 : 10;
    end else if (e_busy) begin
      m_left--;
      if (m_left == 0 && m_p_ok) begin m_hi = m_p_hi; m_lo = m_p_lo; end
    end else if (E_md_op == 4'd7) begin
      m_hi = E_A;
    end else if (E_md_op == 4'd8) begin
      m_lo = E_A;
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic d_use);
    @(posedge clk);
    #1;
    E_md_op = op; E_A = a; E_B = b; D_md_use = d_use;
  endtask

  // Issue op for one cycle, then idle until busy falls; returns busy cycle count.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic d_use, output int nbusy);
    nbusy = 0;
    drive(op, a, b, d_use);
    @(negedge clk);
    check("start_at_T", 32'(start), 32'd1);
    check("stall_at_T", 32'(md_stall), 32'(d_use));
    drive(4'd0, 32'h0, 32'h0, d_use);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      nbusy++;
      check("stall_busy", 32'(md_stall), 32'(d_use));
      if (i == 39) check("busy_timeout", 32'(busy), 32'd0);
      @(posedge clk);
    end
    check("stall_after", 32'(md_stall), 32'd0);
  endtask

  initial begin
    int nb;
    reset = 1'b1; E_md_op = 4'd0; E_A = '0; E_B = '0; D_md_use = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);

    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, nb);
    check("mult_cycles", 32'(nb), 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);
    drive(4'd6, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("mflo_new", E_md_rd, 32'hFFFF_FFFE);

    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, nb);
    check("multu_cycles", 32'(nb), 32'd5);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, nb);
    check("div_cycles", 32'(nb), 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    run_op(4'd4, 32'd7, 32'd2, 1'b0, nb);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    drive(4'd7, 32'h11, 32'h0, 1'b0);
    drive(4'd8, 32'h22, 32'h0, 1'b0);
    run_op(4'd3, 32'h1234, 32'h0, 1'b0, nb);
    check("div0_cycles", 32'(nb), 32'd10);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    drive(4'd3, 32'd100, 32'd7, 1'b0);
    drive(4'd0, 32'h0, 32'h0, 1'b0);
    repeat (3) drive(4'd0, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;
    drive(4'd8, 32'h5, 32'h0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_hi", hi, 32'h0);
    drive(4'd0, 32'h0, 32'h0, 1'b0);
    repeat (12) drive(4'd0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("rst_mtlo_lo", lo, 32'h5);
    check("rst_nocommit_hi", hi, 32'h0);

    for (int c = 0; c < 3000; c++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 8));
      case ($urandom_range(0, 7))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      reset = ($urandom_range(0, 199) == 0);
      drive(op, a, b, 1'($urandom_range(0, 1)));
    end
    reset = 1'b0;
    drive(4'd0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multiply/divide scheduler for the pipelined MIPS core; sits beside the ALU in the E stage.
- Owns the HI/LO registers and a latency counter that models multi-cycle mult/div.
- Produces the D-stage stall request so that no HI/LO-class instruction issues while an operation is in flight.
- Serves mfhi/mflo reads and mthi/mtlo writes.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- E_md_op  input  4  md opcode of the instruction in the E stage (encoding in head.v)
- E_A  input  32  forwarded rs value in E
- E_B  input  32  forwarded rt value in E
- D_md_use  input  1  instruction in D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- start  output  1  combinational; E holds mult/multu/div/divu and busy==0
- busy  output  1  registered; operation in flight
- md_stall  output  1  combinational; D_md_use && (start || busy)
- E_md_rd  output  32  combinational; HI when E_md_op==MFHI, LO when MFLO, else 0
- hi  output  32  current HI register
- lo  output  32  current LO register

Behaviour:
- Reset (synchronous, active-high):
  - hi, lo, counter, pending registers all reset to 0.
  - busy=0 from the cycle after the reset edge.
  - Reset asserted mid-operation discards the pending result; HI/LO are not written.
- Op classes:
  - NONE: no action.
  - MULT/MULTU: 64-bit product; HI = upper 32 bits, LO = lower 32 bits. Signed for MULT, unsigned for MULTU.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed uses truncation toward zero; remainder takes the sign of the dividend.
  - MTHI/MTLO: write E_A to HI/LO.
  - MFHI/MFLO: read only.
- Start at cycle T (E_md_op is a mult/div op and busy==0):
  - At the edge ending T: compute the result from E_A/E_B, latch it into pend_hi/pend_lo, load the counter with MULT_CYCLES or DIV_CYCLES.
- Busy period:
  - busy = (counter != 0).
  - Each edge with counter != 0 decrements it.
  - The edge where counter==1 commits pend_hi/pend_lo to hi/lo.
  - With default parameters: busy is high in T+1..T+5 (mult) or T+1..T+10 (div); the new HI/LO is visible from T+6 / T+11.
- Divide by zero: no commit; HI/LO keep their old values. Busy timing is unchanged (DIV_CYCLES).
- MTHI/MTLO: write at the edge ending the E cycle, effective only when busy==0 and start==0. If issued while busy (illegal; prevented by the stall) the write is ignored.
- Mult/div op in E while busy==1: illegal. start stays 0 and the op is ignored; the in-flight operation is unaffected.
- mfhi/mflo in E while busy: illegal. E_md_rd still returns the current (old) register value.
- Commit edge coinciding with a new start: not possible, because start requires busy==0. The first new start can occur in the cycle after busy falls.
- md_stall covers the start cycle itself: a D-stage md instruction behind a starting mult stalls from cycle T.
- Non-md instructions are never stalled by this block.
- No other outputs are registered; latency is otherwise zero.

Decomposition:
- head.v (shared macros):
  - md op encodings: MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
  - default cycle counts.
- Optional sub-module md_calc: purely combinational; (op, A, B) -> {res_hi, res_lo, div0}. Keeps the arithmetic apart from the sequencing.
- Controller gains the E_md_op decode and the D_md_use output; the hazard unit ORs md_stall into the D-stage stall.

Test Plan:
- reset, then MULT with A=0xFFFFFFFF, B=2 in E at T -> start=1 at T; busy=1 for T+1..T+5; from T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- DIV A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7, B=2 -> lo=3, hi=1.
- DIV by B=0 with hi=0x11, lo=0x22 preset via MTHI/MTLO -> busy still 10 cycles; hi=0x11, lo=0x22 unchanged.
- MULT at T with D_md_use=1 (mflo in D) -> md_stall=1 in T..T+5, 0 at T+6; mflo in E at T+6 gives E_md_rd = new lo. With D_md_use=0 (addu in D), md_stall=0 throughout.
- DIV started, reset asserted at T+4 -> busy=0, hi=lo=0 after the edge, no later commit; MTLO A=0x5 next cycle -> lo=0x5.
